// File: rtl/ib_pkg.sv
// Shared definitions for the ib multiply-accumulate slice: state encoding and operand widths.
package ib_pkg;

  localparam int IB_MUL_W  = 8;
  localparam int IB_PROD_W = 2 * IB_MUL_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    ACC   = 3'd3,
    OUT   = 3'd4
  } ib_mac_state_t;

endpackage

// File: rtl/ib_mac_8x8_if.sv
// Operand stream, multiplier start/done pair and result bus of the ib_mac_8x8 stage.
interface ib_mac_8x8_if #(
  parameter int ACC_W = 24
);
  import ib_pkg::*;

  logic                 i_valid;
  logic                 o_ready;
  logic [IB_MUL_W-1:0]  i_a;
  logic [IB_MUL_W-1:0]  i_b;
  logic                 o_mul_start;
  logic [IB_MUL_W-1:0]  o_mul_a;
  logic [IB_MUL_W-1:0]  o_mul_b;
  logic [IB_PROD_W-1:0] i_mul_c;
  logic                 i_mul_done;
  logic [ACC_W-1:0]     o_sum;
  logic                 o_sum_valid;
  logic                 o_busy;

  // The accumulator stage is the slave; the surrounding source/multiplier/sink is the master.
  modport slave (
    input  i_valid, i_a, i_b, i_mul_c, i_mul_done,
    output o_ready, o_mul_start, o_mul_a, o_mul_b, o_sum, o_sum_valid, o_busy
  );

  modport master (
    output i_valid, i_a, i_b, i_mul_c, i_mul_done,
    input  o_ready, o_mul_start, o_mul_a, o_mul_b, o_sum, o_sum_valid, o_busy
  );

endinterface

// File: rtl/ib_mul_8x8_s0_l8.sv
// Sequential shift-add 8x8 multiplier; start is registered once, so done from the previous
// operation stays visible for one cycle after the start pulse.
module ib_mul_8x8_s0_l8
  import ib_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_start,
  input  logic [IB_MUL_W-1:0]  i_a,
  input  logic [IB_MUL_W-1:0]  i_b,
  output logic [IB_PROD_W-1:0] o_c,
  output logic                 o_done
);

  logic                 start_q;
  logic [IB_PROD_W-1:0] mcand;
  logic [IB_MUL_W-1:0]  mplier;
  logic [3:0]           cnt;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      start_q <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      o_c     <= '0;
      o_done  <= 1'b0;
    end else begin
      start_q <= i_start;
      if (start_q) begin
        mcand  <= IB_PROD_W'(i_a);
        mplier <= i_b;
        o_c    <= '0;
        cnt    <= 4'd8;
        o_done <= 1'b0;
      end else if (cnt != 4'd0) begin
        // done is a level that stays high until the next start is seen
        if (mplier[0]) begin
          o_c <= o_c + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          o_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ib_mac_8x8.sv
// Sequences operand pairs into an external 8x8 multiplier and accumulates N products
// into a dot-product result presented with a one-cycle valid pulse.
module ib_mac_8x8
  import ib_pkg::*;
#(
  parameter int N     = 8,
  parameter int ACC_W = 24,
  parameter int GUARD = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  ib_mac_8x8_if.slave bus
);

  localparam logic [7:0] LAST_IDX   = 8'(N - 1);
  localparam logic [7:0] GUARD_INIT = 8'(GUARD);

  ib_mac_state_t        state;
  ib_mac_state_t        next_state;
  logic [IB_MUL_W-1:0]  mul_a;
  logic [IB_MUL_W-1:0]  mul_b;
  logic [7:0]           guard_cnt;
  logic [IB_PROD_W-1:0] prod_q;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_next;
  logic [7:0]           count;
  logic [ACC_W-1:0]     sum;

  assign acc_next = acc + ACC_W'(prod_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.i_valid) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if ((guard_cnt == 8'd0) && bus.i_mul_done) next_state = ACC;
      ACC:     next_state = (count == LAST_IDX) ? OUT : IDLE;
      OUT:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready     = (state == IDLE);
    bus.o_mul_start = (state == START);
    bus.o_sum_valid = (state == OUT);
    bus.o_busy      = (state != IDLE);
  end

  // o_sum is loaded on the last ACC so it is already stable in the OUT cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mul_a     <= '0;
      mul_b     <= '0;
      guard_cnt <= '0;
      prod_q    <= '0;
      acc       <= '0;
      count     <= '0;
      sum       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            mul_a <= bus.i_a;
            mul_b <= bus.i_b;
          end
        end
        START: guard_cnt <= GUARD_INIT;
        WAIT: begin
          if (guard_cnt != 8'd0) begin
            guard_cnt <= guard_cnt - 8'd1;
          end else if (bus.i_mul_done) begin
            prod_q <= bus.i_mul_c;
          end
        end
        ACC: begin
          acc   <= acc_next;
          count <= count + 8'd1;
          if (count == LAST_IDX) begin
            sum <= acc_next;
          end
        end
        OUT: begin
          acc   <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_mul_a = mul_a;
  assign bus.o_mul_b = mul_b;
  assign bus.o_sum   = sum;

endmodule

// File: tb/tb_ib_mac_8x8.sv
// Directed bench: four accumulator stages (N = 1, 4, 255, 3), each paired with its own
// sequential multiplier, exercised one after another from a single stimulus sequence.
module tb_ib_mac_8x8;
  import ib_pkg::*;

  localparam int NUM_DUT = 4;
  localparam int ACC_W   = 24;
  localparam int LATENCY = 13;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  logic [NUM_DUT-1:0]            valid = '0;
  logic [NUM_DUT-1:0][7:0]       op_a  = '0;
  logic [NUM_DUT-1:0][7:0]       op_b  = '0;
  logic [NUM_DUT-1:0]            ready;
  logic [NUM_DUT-1:0]            mul_start;
  logic [NUM_DUT-1:0]            sum_valid;
  logic [NUM_DUT-1:0]            busy;
  logic [NUM_DUT-1:0][7:0]       mul_a;
  logic [NUM_DUT-1:0][7:0]       mul_b;
  logic [NUM_DUT-1:0][ACC_W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int rd        [NUM_DUT] = '{default: 0};
  int acc_cnt   [NUM_DUT] = '{default: 0};
  int pulse_cnt [NUM_DUT] = '{default: 0};
  int start_cnt [NUM_DUT] = '{default: 0};
  logic [ACC_W-1:0] res_q     [NUM_DUT][$];
  int               res_cyc_q [NUM_DUT][$];
  int               exp_q[$];

  logic [7:0] pair_a [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
  logic [7:0] pair_b [4] = '{8'd2, 8'd4, 8'd6, 8'd8};

  always #5 i_clk = ~i_clk;

  for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
    localparam int NP = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 255 : 3;
    logic [IB_PROD_W-1:0] mul_c;
    logic                 mul_done;

    ib_mac_8x8_if #(.ACC_W(ACC_W)) bus ();

    assign bus.i_valid    = valid[g];
    assign bus.i_a        = op_a[g];
    assign bus.i_b        = op_b[g];
    assign bus.i_mul_c    = mul_c;
    assign bus.i_mul_done = mul_done;
    assign ready[g]       = bus.o_ready;
    assign mul_start[g]   = bus.o_mul_start;
    assign mul_a[g]       = bus.o_mul_a;
    assign mul_b[g]       = bus.o_mul_b;
    assign sum[g]         = bus.o_sum;
    assign sum_valid[g]   = bus.o_sum_valid;
    assign busy[g]        = bus.o_busy;

    ib_mac_8x8 #(.N(NP), .ACC_W(ACC_W), .GUARD(1)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
    );

    ib_mul_8x8_s0_l8 mul (
      .i_clk   (i_clk),
      .i_nrst  (~i_rst),
      .i_start (bus.o_mul_start),
      .i_a     (bus.o_mul_a),
      .i_b     (bus.o_mul_b),
      .o_c     (mul_c),
      .o_done  (mul_done)
    );
  end

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NUM_DUT; k++) begin
      if (valid[k] && ready[k]) acc_cnt[k] <= acc_cnt[k] + 1;
    end
  end

  always @(negedge i_clk) begin
    for (int k = 0; k < NUM_DUT; k++) begin
      if (sum_valid[k]) begin
        res_q[k].push_back(sum[k]);
        res_cyc_q[k].push_back(cyc);
        pulse_cnt[k] <= pulse_cnt[k] + 1;
      end
      if (mul_start[k]) start_cnt[k] <= start_cnt[k] + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic checkReset(input int k);
    checkOutput($sformatf("rst_ready_%0d", k),     32'(ready[k]),     32'd1);
    checkOutput($sformatf("rst_start_%0d", k),     32'(mul_start[k]), 32'd0);
    checkOutput($sformatf("rst_mul_a_%0d", k),     32'(mul_a[k]),     32'd0);
    checkOutput($sformatf("rst_mul_b_%0d", k),     32'(mul_b[k]),     32'd0);
    checkOutput($sformatf("rst_sum_%0d", k),       32'(sum[k]),       32'd0);
    checkOutput($sformatf("rst_sum_valid_%0d", k), 32'(sum_valid[k]), 32'd0);
    checkOutput($sformatf("rst_busy_%0d", k),      32'(busy[k]),      32'd0);
  endtask

  // Entered and left on a falling edge; the pair is taken on the rising edge where ready was seen.
  task automatic applyStimulus(input int k, input logic [7:0] a, input logic [7:0] b, input bit hold_valid);
    bit accepted;
    accepted = 1'b0;
    valid[k] = 1'b1;
    op_a[k]  = a;
    op_b[k]  = b;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (ready[k]) begin
        last_acc_cyc = cyc;
        accepted = 1'b1;
        @(posedge i_clk);
      end
      @(negedge i_clk);
    end
    if (!hold_valid || !accepted) valid[k] = 1'b0;
    checkOutput("accept", 32'(accepted), 32'd1);
  endtask

  task automatic waitResult(input int k, input string tag, input logic [31:0] expected, input int exp_latency);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (res_q[k].size() > rd[k]) seen = 1'b1;
      else @(negedge i_clk);
    end
    checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput(tag, 32'(res_q[k][rd[k]]), expected);
      if (exp_latency > 0)
        checkOutput({tag, "_latency"}, 32'(res_cyc_q[k][rd[k]] - last_acc_cyc), 32'(exp_latency));
      rd[k]++;
    end
  endtask

  initial begin
    int         model_acc;
    int         base_acc;
    logic [7:0] ra;
    logic [7:0] rb;

    $display("[TB] reset");
    repeat (2) @(negedge i_clk);
    checkReset(0);
    checkReset(1);
    i_rst = 1'b0;
    @(negedge i_clk);

    $display("[TB] N=1 full-scale product");
    applyStimulus(0, 8'd255, 8'd255, 1'b0);
    checkOutput("n1_start_high", 32'(mul_start[0]), 32'd1);
    checkOutput("n1_busy",       32'(busy[0]),      32'd1);
    checkOutput("n1_ready_low",  32'(ready[0]),     32'd0);
    checkOutput("n1_mul_a",      32'(mul_a[0]),     32'd255);
    checkOutput("n1_mul_b",      32'(mul_b[0]),     32'd255);
    waitResult(0, "n1_sum", 32'd65025, LATENCY);
    repeat (3) @(negedge i_clk);
    checkOutput("n1_pulses",       32'(pulse_cnt[0]), 32'd1);
    checkOutput("n1_start_cycles", 32'(start_cnt[0]), 32'd1);
    checkOutput("n1_sum_hold",     32'(sum[0]),       32'd65025);
    checkOutput("n1_ready_back",   32'(ready[0]),     32'd1);

    // The multiplier's done is still high from 255*255 when this pair starts
    $display("[TB] stale done masking");
    applyStimulus(0, 8'd3, 8'd5, 1'b0);
    waitResult(0, "stale_sum", 32'd15, LATENCY);
    repeat (2) @(negedge i_clk);
    checkOutput("stale_pulses", 32'(pulse_cnt[0]), 32'd2);

    $display("[TB] reset while waiting on the multiplier");
    applyStimulus(1, 8'd9, 8'd9, 1'b0);
    applyStimulus(1, 8'd10, 8'd10, 1'b0);
    applyStimulus(1, 8'd11, 8'd11, 1'b0);
    repeat (4) @(negedge i_clk);
    checkOutput("pre_rst_busy",  32'(busy[1]),  32'd1);
    checkOutput("pre_rst_mul_a", 32'(mul_a[1]), 32'd11);
    i_rst = 1'b1;
    #1;
    checkReset(1);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    $display("[TB] N=4 dot product");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, pair_a[i], pair_b[i], 1'b0);
      checkOutput("n4_ready_low", 32'(ready[1]), 32'd0);
      checkOutput("n4_busy",      32'(busy[1]),  32'd1);
    end
    waitResult(1, "n4_sum", 32'd100, LATENCY);
    repeat (3) @(negedge i_clk);
    checkOutput("n4_sum_hold",  32'(sum[1]),       32'd100);
    checkOutput("n4_valid_low", 32'(sum_valid[1]), 32'd0);
    checkOutput("n4_pulses",    32'(pulse_cnt[1]), 32'd1);

    $display("[TB] N=255 maximum accumulation");
    for (int i = 0; i < 255; i++) applyStimulus(2, 8'd255, 8'd255, 1'b0);
    waitResult(2, "n255_sum", 32'd16581375, LATENCY);

    $display("[TB] N=3 continuous valid, 1000 results");
    model_acc = 0;
    base_acc  = acc_cnt[3];
    for (int i = 0; i < 3000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      model_acc += int'(ra) * int'(rb);
      if (i % 3 == 2) begin
        exp_q.push_back(model_acc);
        model_acc = 0;
      end
      applyStimulus(3, ra, rb, 1'b1);
    end
    valid[3] = 1'b0;
    for (int i = 0; i < 100 && res_q[3].size() < 1000; i++) @(negedge i_clk);
    checkOutput("bp_result_count", 32'(res_q[3].size()), 32'd1000);
    checkOutput("bp_accept_count", 32'(acc_cnt[3] - base_acc), 32'd3000);
    for (int i = 0; i < exp_q.size() && i < res_q[3].size(); i++)
      checkOutput($sformatf("bp_sum_%0d", i), 32'(res_q[3][i]), 32'(exp_q[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
